// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter: turns a registered-read FIFO pull port into a valid/ready stream source
module fifo_stream_adapter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fifo_rd_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CNT_W-1:0] xfer_count
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             inflight;
    logic             deq;

    assign deq        = m_valid && m_ready;
    assign m_valid    = count != 2'd0;
    assign m_data     = mem[rd_ptr];
    assign fifo_rd_en = !rst && !fifo_empty && ({1'b0, count} + {2'b0, inflight} - {2'b0, deq} < 3'd2);

    // Two-entry skid buffer fed by the in-flight FIFO read, drained by stream handshakes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0]     <= '0;
            mem[1]     <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            inflight   <= 1'b0;
            xfer_count <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (inflight) begin
                mem[wr_ptr] <= fifo_rd_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr     <= ~rd_ptr;
                xfer_count <= xfer_count + CNT_W'(1);
            end
            count <= count + {1'b0, inflight} - {1'b0, deq};
        end
    end
endmodule

// File: tb/tb_fifo_stream_adapter.sv
// tb_fifo_stream_adapter: directed and randomized checks of the FIFO-to-stream adapter
module tb_fifo_stream_adapter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_en;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;
    logic [3:0] xfer_count;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] fm [0:2047];
    int         fwp;
    int         frp;
    logic [7:0] sb [$];
    logic       prev_stall;
    logic [7:0] prev_data;
    int         rd_pulses;
    int         n_checks = 0;
    int         n_errors = 0;

    fifo_stream_adapter #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (fwp == frp);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Upstream FIFO model: registered read data one cycle after rd_en, cleared by shared rst
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fwp          <= 0;
            frp          <= 0;
            fifo_rd_data <= 8'h00;
        end else begin
            if (wr_en) begin
                fm[fwp % 2048] <= wr_data;
                fwp            <= fwp + 1;
            end
            if (fifo_rd_en) begin
                fifo_rd_data <= fm[frp % 2048];
                frp          <= frp + 1;
            end
        end
    end

    // Scoreboard and protocol monitor sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
            rd_pulses  = 0;
        end else begin
            if (wr_en) sb.push_back(wr_data);
            if (fifo_empty) check("rd_en_while_empty", {31'b0, fifo_rd_en}, 32'd0);
            if (prev_stall) check("hold_data", {24'b0, m_data}, {24'b0, prev_data});
            if (fifo_rd_en) rd_pulses++;
            if (m_valid && m_ready) begin
                check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) check("order", {24'b0, m_data}, {24'b0, sb.pop_front()});
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic do_reset();
        rst     = 1'b1;
        m_ready = 1'b0;
        wr_en   = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    initial begin
        logic [7:0] got [$];
        int first_v;
        int last_v;
        int written;
        #1;
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // single word
        do_reset();
        m_ready = 1'b1;
        wr(8'hA5);
        @(negedge clk);
        check("single_c0_rd_en", {31'b0, fifo_rd_en}, 32'd1);
        check("single_c0_valid", {31'b0, m_valid}, 32'd0);
        @(negedge clk);
        check("single_c1_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        check("single_c1_valid", {31'b0, m_valid}, 32'd0);
        @(negedge clk);
        check("single_c2_valid", {31'b0, m_valid}, 32'd1);
        check("single_c2_data", {24'b0, m_data}, 32'hA5);
        @(negedge clk);
        check("single_c3_valid", {31'b0, m_valid}, 32'd0);
        check("single_c3_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        check("single_xfer", {28'b0, xfer_count}, 32'd1);

        // streaming 0x01..0x08
        do_reset();
        for (int i = 1; i <= 8; i++) wr(8'(i));
        m_ready = 1'b1;
        first_v = -1;
        last_v  = -1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (m_valid) begin
                got.push_back(m_data);
                if (first_v < 0) first_v = c;
                last_v = c;
            end
        end
        check("stream_words", 32'(got.size()), 32'd8);
        check("stream_contiguous", 32'(last_v - first_v + 1), 32'd8);
        for (int i = 0; i < got.size(); i++) check("stream_data", {24'b0, got[i]}, 32'(i + 1));
        check("stream_xfer", {28'b0, xfer_count}, 32'd8);
        check("stream_valid_end", {31'b0, m_valid}, 32'd0);

        // asynchronous reset mid-stream
        @(posedge clk);
        #1 m_ready = 1'b0;
        wr(8'h55);
        wr(8'h66);
        wr(8'h77);
        repeat (4) @(posedge clk);
        #1 m_ready = 1'b1;
        #1;
        check("pre_rst_valid", {31'b0, m_valid}, 32'd1);
        check("pre_rst_data", {24'b0, m_data}, 32'h55);
        check("pre_rst_rd_en", {31'b0, fifo_rd_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", {31'b0, m_valid}, 32'd0);
        check("async_rst_data", {24'b0, m_data}, 32'd0);
        check("async_rst_xfer", {28'b0, xfer_count}, 32'd0);
        check("async_rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // backpressure
        do_reset();
        for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
        repeat (10) @(posedge clk);
        #1;
        check("bp_rd_pulses", 32'(rd_pulses), 32'd2);
        check("bp_valid", {31'b0, m_valid}, 32'd1);
        check("bp_head", {24'b0, m_data}, 32'h10);
        m_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("bp_xfer", {28'b0, xfer_count}, 32'd5);
        check("bp_sb_drained", 32'(sb.size()), 32'd0);
        check("bp_valid_end", {31'b0, m_valid}, 32'd0);
        check("bp_rd_total", 32'(rd_pulses), 32'd5);

        // counter wrap with 4-bit counter
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) wr(8'hC0 + 8'(i));
        repeat (8) @(posedge clk);
        #1;
        check("wrap_xfer", {28'b0, xfer_count}, 32'd1);
        check("wrap_sb_drained", 32'(sb.size()), 32'd0);

        // random traffic
        do_reset();
        written = 0;
        while (written < 1000) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_data = 8'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            if (wr_en) written++;
            @(posedge clk);
            #1;
        end
        wr_en   = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 5000 && (sb.size() != 0 || m_valid); c++) @(posedge clk);
        #1;
        check("rand_drained", 32'(sb.size()), 32'd0);
        check("rand_valid_end", {31'b0, m_valid}, 32'd0);
        check("rand_xfer", {28'b0, xfer_count}, 32'(1000 % 16));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
